// File: rtl/calc_cmd_issuer.sv
// calc_cmd_issuer: buffers calculator commands in a small FIFO, issues them one
// at a time (operands + one-cycle Go), waits for Done and hands the captured
// result to a valid/ready consumer. A watchdog turns a missing Done into a
// timeout result so the queue never stalls.
//
// Handshakes: a transfer happens on the rising clk edge where valid && ready
// are both high. A producer holds its payload steady while valid is high and
// ready is low; res_* is held stable in HOLD until res_ready is seen.
module calc_cmd_issuer #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [2:0]               cmd_in1,
    input  logic [2:0]               cmd_in2,
    input  logic [1:0]               cmd_op,
    output logic [2:0]               calc_in1,
    output logic [2:0]               calc_in2,
    output logic [1:0]               calc_op,
    output logic                     calc_go,
    input  logic                     calc_done,
    input  logic [2:0]               calc_out,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [2:0]               res_data,
    output logic [1:0]               res_op,
    output logic                     res_timeout,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    fifo_mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    in1_q, in1_d, in2_q, in2_d;
    logic [1:0]    op_q, op_d;
    logic [2:0]    res_data_q, res_data_d;
    logic [1:0]    res_op_q, res_op_d;
    logic          res_timeout_q, res_timeout_d;
    logic          push, pop;
    logic [7:0]    head;

    // No full-bypass: readiness depends on the registered count only.
    assign cmd_ready = (count_q < CW'(DEPTH));
    assign push      = cmd_valid && cmd_ready;
    assign head      = fifo_mem_q[rd_ptr_q];

    // Moore outputs decoded straight from the state register.
    assign calc_go     = (state_q == ISSUE);
    assign res_valid   = (state_q == HOLD);
    assign busy        = (state_q != IDLE);
    assign calc_in1    = in1_q;
    assign calc_in2    = in2_q;
    assign calc_op     = op_q;
    assign res_data    = res_data_q;
    assign res_op      = res_op_q;
    assign res_timeout = res_timeout_q;
    assign fifo_count  = count_q;

    // Command storage; entries are packed {op, in2, in1}.
    always_ff @(posedge clk) begin
        if (push) fifo_mem_q[wr_ptr_q] <= {cmd_op, cmd_in2, cmd_in1};
    end

    // FIFO pointer and occupancy update; pointers wrap naturally (DEPTH is 2^n).
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (push && !pop)      count_d = count_q + CW'(1);
        else if (!push && pop) count_d = count_q - CW'(1);
    end

    // Sequencer: next state, pop request, operand load, watchdog and result capture.
    always_comb begin
        state_d       = state_q;
        pop           = 1'b0;
        timer_d       = timer_q;
        in1_d         = in1_q;
        in2_d         = in2_q;
        op_d          = op_q;
        res_data_d    = res_data_q;
        res_op_d      = res_op_q;
        res_timeout_d = res_timeout_q;
        case (state_q)
            IDLE: begin
                // A Done still high from a previous run blocks the next issue.
                if (count_q != '0 && !calc_done) begin
                    pop     = 1'b1;
                    in1_d   = head[2:0];
                    in2_d   = head[5:3];
                    op_d    = head[7:6];
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                timer_d = '0;
                state_d = WAIT;
            end
            WAIT: begin
                timer_d = timer_q + TW'(1);
                // Done takes priority over a watchdog expiry in the same cycle.
                if (calc_done) begin
                    res_data_d    = calc_out;
                    res_op_d      = op_q;
                    res_timeout_d = 1'b0;
                    state_d       = HOLD;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    res_data_d    = '0;
                    res_op_d      = op_q;
                    res_timeout_d = 1'b1;
                    state_d       = HOLD;
                end
            end
            HOLD: begin
                if (res_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, pointer and datapath registers; reset discards any in-flight work.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            timer_q       <= '0;
            in1_q         <= '0;
            in2_q         <= '0;
            op_q          <= '0;
            res_data_q    <= '0;
            res_op_q      <= '0;
            res_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            timer_q       <= timer_d;
            in1_q         <= in1_d;
            in2_q         <= in2_d;
            op_q          <= op_d;
            res_data_q    <= res_data_d;
            res_op_q      <= res_op_d;
            res_timeout_q <= res_timeout_d;
        end
    end
endmodule

// File: tb/tb_calc_cmd_issuer.sv
// Testbench for calc_cmd_issuer: a behavioural calculator with configurable
// Done latency, an in-order expected-command queue, and one task per scenario.
module tb_calc_cmd_issuer;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 15;
    localparam int CW      = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid, cmd_ready;
    logic [2:0]    cmd_in1, cmd_in2;
    logic [1:0]    cmd_op;
    logic [2:0]    calc_in1, calc_in2;
    logic [1:0]    calc_op;
    logic          calc_go, calc_done;
    logic [2:0]    calc_out;
    logic          res_valid, res_ready;
    logic [2:0]    res_data;
    logic [1:0]    res_op;
    logic          res_timeout, busy;
    logic [CW-1:0] fifo_count;

    int checks   = 0;
    int errors   = 0;
    int go_count = 0;

    // Commands accepted and not yet answered, oldest first: {op, in2, in1}.
    logic [7:0] exp_q[$];

    // Calculator model controls.
    logic       force_done = 1'b0;
    logic       rand_lat   = 1'b0;
    logic [4:0] lat_cfg    = 5'd5;
    logic [4:0] m_cnt;
    logic [2:0] m_out;

    logic [20:0] out_vec;
    assign out_vec = {cmd_ready, calc_go, res_valid, res_timeout, busy, calc_in1, calc_in2,
                      calc_op, res_data, res_op, fifo_count};

    calc_cmd_issuer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_in1(cmd_in1), .cmd_in2(cmd_in2), .cmd_op(cmd_op),
        .calc_in1(calc_in1), .calc_in2(calc_in2), .calc_op(calc_op),
        .calc_go(calc_go), .calc_done(calc_done), .calc_out(calc_out),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_op(res_op), .res_timeout(res_timeout),
        .busy(busy), .fifo_count(fifo_count)
    );

    // Clock
    always #5 clk = ~clk;

    // What the calculator computes for a command {op, in2, in1}.
    function automatic logic [2:0] calc_ref(input logic [7:0] c);
        logic [2:0] a, b;
        a = c[2:0];
        b = c[5:3];
        case (c[7:6])
            2'd0:    return 3'(a + b);
            2'd1:    return 3'(a - b);
            2'd2:    return a & b;
            default: return a ^ b;
        endcase
    endfunction

    function automatic logic [7:0] rand_cmd();
        return 8'($urandom);
    endfunction

    // Calculator model: Done pulses lat cycles after Go is sampled (lat 0 = never).
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cnt <= '0;
            m_out <= '0;
        end else if (calc_go) begin
            m_cnt <= rand_lat ? 5'($urandom_range(1, 8)) : lat_cfg;
            m_out <= calc_ref({calc_op, calc_in2, calc_in1});
        end else if (m_cnt != 0) begin
            m_cnt <= m_cnt - 5'd1;
        end
    end
    assign calc_done = (m_cnt == 5'd1) || force_done;
    assign calc_out  = m_out;

    always @(posedge clk) if (calc_go === 1'b1) go_count++;

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_cmd(input logic [7:0] c, output bit ok);
        bit acc;
        ok = 1'b0;
        cmd_valid = 1'b1;
        cmd_in1 = c[2:0];
        cmd_in2 = c[5:3];
        cmd_op  = c[7:6];
        for (int i = 0; i < 200; i++) begin
            acc = cmd_ready;
            tick();
            if (acc) begin
                ok = 1'b1;
                exp_q.push_back(c);
                break;
            end
        end
        cmd_valid = 1'b0;
    endtask

    task automatic wait_res(input int limit, output int n);
        n = 0;
        while (res_valid !== 1'b1 && n <= limit) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_go(input int limit, output int n);
        n = 0;
        while (calc_go !== 1'b1 && n <= limit) begin
            tick();
            n++;
        end
    endtask

    task automatic accept();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (out_vec !== 21'h100000) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected %h", out_vec, 21'h100000);
        end
        rst = 1'b0;
        tick();
        tick();
        checks++;
        if (out_vec !== 21'h100000) begin
            errors++;
            $display("FAIL idle_after_reset: got %h expected %h", out_vec, 21'h100000);
        end
    endtask

    task automatic test_single();
        bit ok, stable;
        int n, g0;
        logic [7:0] e;
        lat_cfg = 5'd5;
        g0 = go_count;
        push_cmd({2'd0, 3'd2, 3'd3}, ok);
        checks++;
        if (!ok || fifo_count !== CW'(1)) begin
            errors++;
            $display("FAIL single_push: accepted %0b count %0d expected 1/1", ok, fifo_count);
        end
        tick();
        checks++;
        if ({calc_go, calc_in1, calc_in2, calc_op, fifo_count} !== {1'b1, 3'd3, 3'd2, 2'd0, CW'(0)}) begin
            errors++;
            $display("FAIL single_issue: go %b in1 %0d in2 %0d op %0d count %0d expected 1/3/2/0/0",
                     calc_go, calc_in1, calc_in2, calc_op, fifo_count);
        end
        tick();
        stable = 1'b1;
        n = 0;
        while (res_valid !== 1'b1 && n < 40) begin
            if (calc_in1 !== 3'd3 || calc_in2 !== 3'd2 || calc_op !== 2'd0) stable = 1'b0;
            tick();
            n++;
        end
        checks++;
        if (n != 5) begin
            errors++;
            $display("FAIL single_latency: got %0d cycles expected 5", n);
        end
        e = exp_q.pop_front();
        checks++;
        if ({res_valid, res_timeout, res_op, res_data} !== {1'b1, 1'b0, e[7:6], calc_ref(e)} || res_data !== 3'd5) begin
            errors++;
            $display("FAIL single_result: got v%b t%b op%0d data%0d expected v1 t0 op0 data5",
                     res_valid, res_timeout, res_op, res_data);
        end
        checks++;
        if (!stable || go_count - g0 != 1 || fifo_count !== CW'(0)) begin
            errors++;
            $display("FAIL single_stable: stable %0b go pulses %0d count %0d expected 1/1/0",
                     stable, go_count - g0, fifo_count);
        end
        accept();
        checks++;
        if (res_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_release: res_valid %b busy %b expected 0/0", res_valid, busy);
        end
    endtask

    task automatic test_fill();
        bit ok, all_ok, blocked;
        int n, g0;
        logic [7:0] c5, e;
        force_done = 1'b1;
        lat_cfg = 5'd3;
        all_ok = 1'b1;
        g0 = go_count;
        for (int i = 0; i < DEPTH; i++) begin
            push_cmd(rand_cmd(), ok);
            all_ok &= ok;
        end
        checks++;
        if (!all_ok || fifo_count !== CW'(DEPTH) || cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL fill_full: accepted %0b count %0d ready %b expected 1/%0d/0",
                     all_ok, fifo_count, cmd_ready, DEPTH);
        end
        c5 = rand_cmd();
        cmd_valid = 1'b1;
        cmd_in1 = c5[2:0];
        cmd_in2 = c5[5:3];
        cmd_op  = c5[7:6];
        blocked = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (cmd_ready !== 1'b0) blocked = 1'b0;
            tick();
        end
        checks++;
        if (!blocked || fifo_count !== CW'(DEPTH) || go_count != g0) begin
            errors++;
            $display("FAIL fill_refused: blocked %0b count %0d go pulses %0d expected 1/%0d/0",
                     blocked, fifo_count, go_count - g0, DEPTH);
        end
        force_done = 1'b0;
        n = 0;
        ok = 1'b0;
        while (!ok && n < 10) begin
            ok = cmd_ready;
            tick();
            n++;
        end
        cmd_valid = 1'b0;
        if (ok) exp_q.push_back(c5);
        checks++;
        if (!ok || n != 2) begin
            errors++;
            $display("FAIL fill_fifth_accept: accepted %0b after %0d edges expected 1 after 2", ok, n);
        end
        for (int i = 0; i <= DEPTH; i++) begin
            wait_res(60, n);
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
            checks++;
            if ({res_valid, res_timeout, res_op, res_data} !== {1'b1, 1'b0, e[7:6], calc_ref(e)}) begin
                errors++;
                $display("FAIL fill_order[%0d]: got v%b t%b op%0d data%0d expected v1 t0 op%0d data%0d",
                         i, res_valid, res_timeout, res_op, res_data, e[7:6], calc_ref(e));
            end
            accept();
        end
    endtask

    task automatic test_hold();
        bit ok, held;
        int n, g0;
        logic [7:0] e;
        logic [5:0] snap;
        lat_cfg = 5'd3;
        push_cmd(rand_cmd(), ok);
        push_cmd(rand_cmd(), ok);
        wait_res(60, n);
        e = exp_q.pop_front();
        checks++;
        if ({res_valid, res_timeout, res_op, res_data} !== {1'b1, 1'b0, e[7:6], calc_ref(e)}) begin
            errors++;
            $display("FAIL hold_first: got v%b t%b op%0d data%0d expected v1 t0 op%0d data%0d",
                     res_valid, res_timeout, res_op, res_data, e[7:6], calc_ref(e));
        end
        snap = {res_timeout, res_op, res_data};
        g0 = go_count;
        held = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (res_valid !== 1'b1 || {res_timeout, res_op, res_data} !== snap) held = 1'b0;
        end
        checks++;
        if (!held || go_count != g0 || fifo_count !== CW'(1)) begin
            errors++;
            $display("FAIL hold_stable: held %0b go pulses %0d count %0d expected 1/0/1",
                     held, go_count - g0, fifo_count);
        end
        accept();
        checks++;
        if (calc_go !== 1'b0 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL hold_idle_gap: go %b res_valid %b expected 0/0", calc_go, res_valid);
        end
        tick();
        checks++;
        if (calc_go !== 1'b1) begin
            errors++;
            $display("FAIL hold_next_issue: go %b expected 1", calc_go);
        end
        wait_res(60, n);
        e = exp_q.pop_front();
        checks++;
        if ({res_valid, res_timeout, res_op, res_data} !== {1'b1, 1'b0, e[7:6], calc_ref(e)}) begin
            errors++;
            $display("FAIL hold_second: got v%b t%b op%0d data%0d expected v1 t0 op%0d data%0d",
                     res_valid, res_timeout, res_op, res_data, e[7:6], calc_ref(e));
        end
        accept();
    endtask

    task automatic test_timeout();
        bit ok;
        int n;
        logic [7:0] e;
        lat_cfg = 5'd0;
        push_cmd(rand_cmd(), ok);
        push_cmd(rand_cmd(), ok);
        wait_go(20, n);
        wait_res(60, n);
        e = exp_q.pop_front();
        checks++;
        if (n != TIMEOUT + 1 || {res_valid, res_timeout, res_data} !== {1'b1, 1'b1, 3'd0}) begin
            errors++;
            $display("FAIL timeout_result: %0d cycles v%b t%b data%0d expected %0d cycles v1 t1 data0",
                     n, res_valid, res_timeout, res_data, TIMEOUT + 1);
        end
        // Next command: Done lands on the very cycle the watchdog would fire.
        lat_cfg = 5'(TIMEOUT);
        accept();
        wait_go(20, n);
        wait_res(60, n);
        e = exp_q.pop_front();
        checks++;
        if (n != TIMEOUT + 1 || {res_valid, res_timeout, res_op, res_data} !== {1'b1, 1'b0, e[7:6], calc_ref(e)}) begin
            errors++;
            $display("FAIL timeout_done_wins: %0d cycles v%b t%b op%0d data%0d expected %0d cycles v1 t0 op%0d data%0d",
                     n, res_valid, res_timeout, res_op, res_data, TIMEOUT + 1, e[7:6], calc_ref(e));
        end
        accept();
    endtask

    task automatic test_stale_done();
        bit ok, blocked;
        int n, g0;
        logic [7:0] e;
        force_done = 1'b1;
        lat_cfg = 5'd2;
        g0 = go_count;
        push_cmd(rand_cmd(), ok);
        blocked = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (calc_go !== 1'b0) blocked = 1'b0;
            tick();
        end
        checks++;
        if (!blocked || go_count != g0 || fifo_count !== CW'(1)) begin
            errors++;
            $display("FAIL stale_done_block: blocked %0b go pulses %0d count %0d expected 1/0/1",
                     blocked, go_count - g0, fifo_count);
        end
        force_done = 1'b0;
        tick();
        checks++;
        if (calc_go !== 1'b1) begin
            errors++;
            $display("FAIL stale_done_release: go %b expected 1", calc_go);
        end
        wait_res(60, n);
        e = exp_q.pop_front();
        checks++;
        if ({res_valid, res_timeout, res_op, res_data} !== {1'b1, 1'b0, e[7:6], calc_ref(e)}) begin
            errors++;
            $display("FAIL stale_done_result: got v%b t%b op%0d data%0d expected v1 t0 op%0d data%0d",
                     res_valid, res_timeout, res_op, res_data, e[7:6], calc_ref(e));
        end
        accept();
    endtask

    task automatic test_reset_mid();
        bit ok, quiet;
        int n, g0;
        logic [7:0] e;
        lat_cfg = 5'd0;
        for (int i = 0; i < 3; i++) push_cmd(rand_cmd(), ok);
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (fifo_count !== CW'(2) || busy !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_setup: count %0d busy %b expected 2/1", fifo_count, busy);
        end
        #2;
        rst = 1'b1;
        #1;
        exp_q.delete();
        checks++;
        if (out_vec !== 21'h100000) begin
            errors++;
            $display("FAIL rst_mid_async: got %h expected %h", out_vec, 21'h100000);
        end
        tick();
        tick();
        rst = 1'b0;
        g0 = go_count;
        quiet = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (res_valid !== 1'b0 || busy !== 1'b0 || fifo_count !== CW'(0)) quiet = 1'b0;
        end
        checks++;
        if (!quiet || go_count != g0) begin
            errors++;
            $display("FAIL rst_mid_quiet: quiet %0b go pulses %0d expected 1/0", quiet, go_count - g0);
        end
        // Reset while Go is high: Go must drop without waiting for a clock.
        lat_cfg = 5'd4;
        push_cmd(rand_cmd(), ok);
        wait_go(20, n);
        #2;
        rst = 1'b1;
        #1;
        exp_q.delete();
        checks++;
        if (calc_go !== 1'b0 || busy !== 1'b0 || fifo_count !== CW'(0)) begin
            errors++;
            $display("FAIL rst_go_drop: go %b busy %b count %0d expected 0/0/0", calc_go, busy, fifo_count);
        end
        tick();
        rst = 1'b0;
        tick();
        push_cmd(rand_cmd(), ok);
        wait_res(60, n);
        e = exp_q.pop_front();
        checks++;
        if ({res_valid, res_timeout, res_op, res_data} !== {1'b1, 1'b0, e[7:6], calc_ref(e)}) begin
            errors++;
            $display("FAIL rst_fresh_result: got v%b t%b op%0d data%0d expected v1 t0 op%0d data%0d",
                     res_valid, res_timeout, res_op, res_data, e[7:6], calc_ref(e));
        end
        accept();
    endtask

    task automatic test_random();
        rand_lat = 1'b1;
        fork
            begin : producer
                bit ok;
                for (int i = 0; i < 10; i++) begin
                    repeat ($urandom_range(0, 3)) tick();
                    push_cmd(rand_cmd(), ok);
                    checks++;
                    if (!ok) begin
                        errors++;
                        $display("FAIL rand_push[%0d]: accepted 0 expected 1", i);
                    end
                end
            end
            begin : consumer
                int n;
                logic [7:0] e;
                for (int i = 0; i < 10; i++) begin
                    wait_res(200, n);
                    e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
                    checks++;
                    if ({res_valid, res_timeout, res_op, res_data} !== {1'b1, 1'b0, e[7:6], calc_ref(e)}) begin
                        errors++;
                        $display("FAIL rand_result[%0d]: got v%b t%b op%0d data%0d expected v1 t0 op%0d data%0d",
                                 i, res_valid, res_timeout, res_op, res_data, e[7:6], calc_ref(e));
                    end
                    repeat ($urandom_range(0, 3)) tick();
                    accept();
                end
            end
        join
        rand_lat = 1'b0;
        checks++;
        if (exp_q.size() != 0 || fifo_count !== CW'(0)) begin
            errors++;
            $display("FAIL rand_drain: leftover %0d count %0d expected 0/0", exp_q.size(), fifo_count);
        end
    endtask

    // Sequence
    initial begin
        cmd_valid = 1'b0;
        cmd_in1   = '0;
        cmd_in2   = '0;
        cmd_op    = '0;
        res_ready = 1'b0;
        test_reset();
        test_single();
        test_fill();
        test_hold();
        test_timeout();
        test_stale_done();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time limit
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "time limit expired");
    end
endmodule
